id_checker_param: RTL and testbench

ID_CHECKER_PARAM -- requirements
Module: id_checker_param

---
 rtl/id_checker_if.sv | 23 ++
 rtl/id_checker_param.sv | 130 +++++++++++++
 tb/tb_id_checker_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/id_checker_if.sv
// Handshake bundle for id_checker_param: symbol stream in, per-ID result and legal-ID statistics out.
interface id_checker_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [5:0]       in_sym;
    logic             in_mode;
    logic             clr_cnt;
    logic             out_valid;
    logic             out_legal;
    logic             out_err;
    logic [CNT_W-1:0] out_legal_cnt;

    modport master (
        output in_valid, in_sym, in_mode, clr_cnt,
        input  out_valid, out_legal, out_err, out_legal_cnt
    );

    modport slave (
        input  in_valid, in_sym, in_mode, clr_cnt,
        output out_valid, out_legal, out_err, out_legal_cnt
    );
endinterface

// File: rtl/id_checker_param.sv
// Streaming ID checksum checker: national (letter + weighted digits) or Luhn, one symbol per valid cycle,
// registered per-ID verdict and a saturating count of legal IDs.
module id_checker_param #(
    parameter int NUM_DIGITS = 9,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    id_checker_if.slave   bus
);
    localparam int   T     = NUM_DIGITS + 1;
    localparam logic T_ODD = ((T % 2) == 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_nxt;
    logic [3:0]       idx_q, sum_q;
    logic             mode_q, err_q;
    logic             valid_q, legal_q, err_out_q;
    logic [CNT_W-1:0] cnt_q;

    logic             first, last, cur_mode, pos_even, sym_err;
    logic [3:0]       digit, weight, contrib, sum_nxt;
    logic [4:0]       dbl, s5;
    logic [7:0]       prod;
    logic             err_nxt, res_fire, legal_nxt, err_out_nxt;
    int               w_int;

    assign first    = (state_q == IDLE);
    assign last     = (idx_q == 4'(NUM_DIGITS));
    assign cur_mode = first ? bus.in_mode : mode_q;
    assign digit    = bus.in_sym[3:0];
    // Position p = T - j is even exactly when T and j share parity; j is 0 for the first symbol.
    assign pos_even = first ? ~T_ODD : ~(T_ODD ^ idx_q[0]);

    // Contribution of the current symbol, already reduced mod 10.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sym_err = 1'b0;
        prod    = '0;
        dbl     = {digit, 1'b0};
        w_int   = NUM_DIGITS - int'(idx_q);
        weight  = last ? 4'd1 : 4'(w_int % 10);
        if (first && !cur_mode) begin
            if (bus.in_sym < 6'd10 || bus.in_sym > 6'd35)
                sym_err = 1'b1;
            else
                prod = 8'(bus.in_sym / 6'd10) + 8'(bus.in_sym % 6'd10) * 8'd9;
        end else if (bus.in_sym > 6'd9) begin
            sym_err = 1'b1;
        end else if (cur_mode) begin
            if (pos_even)
                prod = 8'((dbl > 5'd9) ? (dbl - 5'd9) : dbl);
            else
                prod = 8'(digit);
        end else begin
            prod = 8'(weight) * 8'(digit);
        end
        contrib = 4'(prod % 8'd10);
    end

    always_comb begin
        s5      = {1'b0, (first ? 4'd0 : sum_q)} + {1'b0, contrib};
        sum_nxt = (s5 >= 5'd10) ? 4'(s5 - 5'd10) : s5[3:0];
        err_nxt = (first ? 1'b0 : err_q) | sym_err;
    end

    // NOTE: async active-low reset and non-blocking assignments for every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)         state_nxt = ACCUM;
            ACCUM:   if (bus.in_valid && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_fire    = (state_q == ACCUM) && bus.in_valid && last;
        legal_nxt   = res_fire && (sum_nxt == 4'd0) && !err_nxt;
        err_out_nxt = res_fire && err_nxt;
    end

    // Datapath: index, running sum, latched mode and sticky error only move on accepted symbols.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            sum_q  <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.in_valid) begin
            idx_q <= first ? 4'd1 : (last ? 4'd0 : 4'(idx_q + 4'd1));
            sum_q <= sum_nxt;
            err_q <= err_nxt;
            if (first) mode_q <= bus.in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            legal_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            valid_q   <= res_fire;
            legal_q   <= legal_nxt;
            err_out_q <= err_out_nxt;
        end
    end

    // The count reflects a verdict at the end of its strobe cycle, so a coinciding clear discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (bus.clr_cnt)
            cnt_q <= '0;
        else if (valid_q && legal_q && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_legal     = legal_q;
    assign bus.out_err       = err_out_q;
    assign bus.out_legal_cnt = cnt_q;
endmodule

// File: tb/tb_id_checker_param.sv
// Directed bench for id_checker_param (NUM_DIGITS=9, CNT_W=8) with hand-computed checksums.
module tb_id_checker_param;
    logic clk = 1'b0;
    logic rst_n;

    id_checker_if #(.CNT_W(8)) bus ();

    id_checker_param #(.NUM_DIGITS(9), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int cyc = 0;
    int npulse = 0;
    int last_pc = 0;
    int prev_pc = 0;
    int np0;
    logic [5:0] id_v [0:9];

    // Strobe monitor: counts result pulses and remembers the cycles of the last two.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid) begin
            npulse  <= npulse + 1;
            prev_pc <= last_pc;
            last_pc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mode is driven only with the first symbol; later symbols carry the opposite mode, which must be ignored.
    task automatic send_id(input logic mode, input bit gaps);
        for (int i = 0; i < 10; i++) begin
            if (gaps && i > 0) repeat ((i % 3) + 1) step();
            bus.in_valid = 1'b1;
            bus.in_sym   = id_v[i];
            bus.in_mode  = (i == 0) ? mode : ~mode;
            step();
            bus.in_valid = 1'b0;
            bus.in_sym   = 6'd63;
        end
    endtask

    // Called one time unit after the edge that accepted the last symbol: strobe must be high now.
    task automatic expect_result(input string tag, input logic legal, input logic err, input bit clr);
        #3;
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_legal"}, bus.out_legal, legal);
        check({tag, "_err"},   bus.out_err,   err);
        if (clr)                         exp_cnt = 0;
        else if (legal && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic after_result(input string tag);
        step();
        check({tag, "_valid_low"}, bus.out_valid, 1'b0);
        check({tag, "_legal_low"}, bus.out_legal, 1'b0);
        check({tag, "_cnt"},       bus.out_legal_cnt, exp_cnt);
    endtask

    task automatic load_national(input logic [5:0] first, input logic [5:0] bad_pos4, input logic [5:0] last_d);
        id_v[0] = first;
        for (int i = 1; i < 9; i++) id_v[i] = 6'(i);
        id_v[4] = bad_pos4;
        id_v[9] = last_d;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sym   = '0;
        bus.in_mode  = 1'b0;
        bus.clr_cnt  = 1'b0;
        repeat (3) step();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_legal", bus.out_legal, 1'b0);
        check("rst_err",   bus.out_err,   1'b0);
        check("rst_cnt",   bus.out_legal_cnt, 0);
        rst_n = 1'b1;
        step();

        // Letter 10 then 1..9: 1+8+14+18+20+20+18+14+8+9 = 130 -> legal.
        load_national(6'd10, 6'd4, 6'd9);
        send_id(1'b0, 1'b0);
        expect_result("nat_legal", 1'b1, 1'b0, 1'b0);
        after_result("nat_legal");

        // Same with last digit 8 -> 129, not legal.
        load_national(6'd10, 6'd4, 6'd8);
        send_id(1'b0, 1'b0);
        expect_result("nat_bad_sum", 1'b0, 1'b0, 1'b0);
        after_result("nat_bad_sum");

        // Letter 35 contributes 3+45=48 -> 8; digits 1..8 give 120; last digit 2 -> 130.
        load_national(6'd35, 6'd4, 6'd2);
        send_id(1'b0, 1'b0);
        expect_result("nat_letter35", 1'b1, 1'b0, 1'b0);
        after_result("nat_letter35");

        // Luhn 1234567897 with 1-3 idle cycles between symbols: 2+2+6+4+1+6+5+8+9+7 = 50.
        for (int i = 0; i < 9; i++) id_v[i] = 6'(i + 1);
        id_v[9] = 6'd7;
        np0 = npulse;
        send_id(1'b1, 1'b1);
        check("luhn_no_early_pulse", npulse, np0);
        expect_result("luhn_gaps", 1'b1, 1'b0, 1'b0);
        after_result("luhn_gaps");
        check("luhn_one_pulse", npulse, np0 + 1);

        // First symbol 5 is not a letter in national mode.
        load_national(6'd5, 6'd4, 6'd9);
        send_id(1'b0, 1'b0);
        expect_result("nat_bad_letter", 1'b0, 1'b1, 1'b0);
        after_result("nat_bad_letter");

        // Digit 12 at position 4; otherwise the legal sequence.
        load_national(6'd10, 6'd12, 6'd9);
        send_id(1'b0, 1'b0);
        expect_result("nat_bad_digit", 1'b0, 1'b1, 1'b0);
        after_result("nat_bad_digit");

        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        exp_cnt = 0;
        check("clr_idle", bus.out_legal_cnt, 0);

        // Two legal IDs back-to-back, second first symbol accepted during the first strobe.
        load_national(6'd10, 6'd4, 6'd9);
        send_id(1'b0, 1'b0);
        expect_result("b2b_first", 1'b1, 1'b0, 1'b0);
        send_id(1'b0, 1'b0);
        expect_result("b2b_second", 1'b1, 1'b0, 1'b0);
        after_result("b2b_second");
        check("b2b_spacing", last_pc - prev_pc, 10);

        // Repeat the pair with a clear coinciding with the second strobe.
        send_id(1'b0, 1'b0);
        expect_result("b2b_clr_first", 1'b1, 1'b0, 1'b0);
        send_id(1'b0, 1'b0);
        bus.clr_cnt = 1'b1;
        expect_result("b2b_clr_second", 1'b1, 1'b0, 1'b1);
        step();
        bus.clr_cnt = 1'b0;
        check("b2b_clr_cnt", bus.out_legal_cnt, exp_cnt);

        // Reset after 5 symbols discards the partial ID.
        bus.clr_cnt = 1'b0;
        exp_cnt = 1;
        step();
        bus.clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sym   = id_v[i];
            bus.in_mode  = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        np0 = npulse;
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_cnt",   bus.out_legal_cnt, 0);
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("mid_rst_no_pulse", npulse, np0);
        send_id(1'b0, 1'b0);
        expect_result("post_rst", 1'b1, 1'b0, 1'b0);
        after_result("post_rst");
        check("post_rst_one_pulse", npulse, np0 + 1);

        // Drive the counter to saturation with back-to-back legal IDs.
        for (int n = 0; n < 256; n++) begin
            send_id(1'b0, 1'b0);
            if (exp_cnt < 255) exp_cnt++;
        end
        repeat (2) step();
        check("sat_reached", bus.out_legal_cnt, exp_cnt);
        send_id(1'b0, 1'b0);
        expect_result("sat_more", 1'b1, 1'b0, 1'b0);
        after_result("sat_more");
        check("sat_holds", bus.out_legal_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
